fetch_decode: RTL and testbench

- Upstream stage of the execute unit.
- Fetches instruction words and any trailing operand words over a `bus_if` master port.
- Decodes each instruction into source and destination unit, immediate and operand fields, then holds `sel_o` high until execute reports completion.
- Owns the program counter and advances it past each instruction and its operand words.

---
 rtl/fetch_decode_pkg.sv | 26 ++
 rtl/bus_if.sv | 12 +
 rtl/fetch_decode_instr_decoder.sv | 22 ++
 rtl/fetch_decode.sv | 107 ++++++++++
 tb/tb_fetch_decode.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_decode_pkg.sv
// fetch_decode_pkg: shared unit encoding, instruction field positions, fetch FSM states
package fetch_decode_pkg;
  typedef enum logic [3:0] {
    UNIT_NONE           = 4'd0,
    UNIT_REGISTER       = 4'd1,
    UNIT_ABS_IMMEDIATE  = 4'd2,
    UNIT_MEMORY_OPERAND = 4'd3,
    UNIT_ABS_OPERAND    = 4'd4
  } Unit;
  typedef enum logic [2:0] {
    FETCH_INSTR,
    FETCH_SRC_OP,
    FETCH_DST_OP,
    ISSUE,
    WAIT
  } state_t;
  localparam int UNIT_W       = 4;
  localparam int IMM_W        = 12;
  localparam int SRC_UNIT_LSB = 0;
  localparam int SRC_IMM_LSB  = 4;
  localparam int DST_UNIT_LSB = 16;
  localparam int DST_IMM_LSB  = 20;
  function automatic logic unit_has_operand(input Unit u);
    return u == UNIT_MEMORY_OPERAND || u == UNIT_ABS_OPERAND;
  endfunction
endpackage

// File: rtl/bus_if.sv
// bus_if: simple valid/ready read bus carrying fetch address, strobes and read data
// master drives addr/valid/wstrb/instr; slave drives ready/read_data.
interface bus_if;
  logic [31:0] addr;
  logic        valid;
  logic [3:0]  wstrb;
  logic        instr;
  logic        ready;
  logic [31:0] read_data;
  modport master(output addr, valid, wstrb, instr, input ready, read_data);
  modport slave(input addr, valid, wstrb, instr, output ready, read_data);
endinterface

// File: rtl/fetch_decode_instr_decoder.sv
// instr_decoder: splits an instruction word into unit/immediate fields and counts operand words
// word in; src/dst unit and immediate, per-side operand flags and total length (1..3 words) out.
module instr_decoder
  import fetch_decode_pkg::*;
(
  input  logic [31:0] word,
  output Unit         src_unit,
  output logic [11:0] src_imm,
  output Unit         dst_unit,
  output logic [11:0] dst_imm,
  output logic        src_has,
  output logic        dst_has,
  output logic [1:0]  len
);
  assign src_unit = Unit'(word[SRC_UNIT_LSB +: UNIT_W]);
  assign src_imm  = word[SRC_IMM_LSB +: IMM_W];
  assign dst_unit = Unit'(word[DST_UNIT_LSB +: UNIT_W]);
  assign dst_imm  = word[DST_IMM_LSB +: IMM_W];
  assign src_has  = unit_has_operand(src_unit);
  assign dst_has  = unit_has_operand(dst_unit);
  assign len      = 2'd1 + {1'b0, src_has} + {1'b0, dst_has};
endmodule

// File: rtl/fetch_decode.sv
// fetch_decode: fetches instructions plus operand words, decodes them and issues to execute
// clk_i/rst_i clock and sync reset; instr_bus fetch master; done_i execute completion;
// sel_o/pc_o issued instruction; src_*/dst_* decoded unit, immediate and operand fields.
module fetch_decode
  import fetch_decode_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  bus_if.master       instr_bus,
  input  logic        done_i,
  output logic        sel_o,
  output logic [31:0] pc_o,
  output Unit         src_unit_o,
  output logic [11:0] src_immediate_o,
  output logic [31:0] src_operand_o,
  output Unit         dst_unit_o,
  output logic [11:0] dst_immediate_o,
  output logic [31:0] dst_operand_o
);
  state_t      state, state_n;
  logic [31:0] pc;
  logic [1:0]  len;
  logic        valid, hs, fetching, skip;
  Unit         dec_src_unit, dec_dst_unit;
  logic [11:0] dec_src_imm, dec_dst_imm;
  logic        dec_src_has, dec_dst_has;
  logic [1:0]  dec_len;

  instr_decoder u_dec (
    .word     (instr_bus.read_data),
    .src_unit (dec_src_unit),
    .src_imm  (dec_src_imm),
    .dst_unit (dec_dst_unit),
    .dst_imm  (dec_dst_imm),
    .src_has  (dec_src_has),
    .dst_has  (dec_dst_has),
    .len      (dec_len)
  );

  assign hs       = valid && instr_bus.ready;
  assign fetching = state inside {FETCH_INSTR, FETCH_SRC_OP, FETCH_DST_OP};
  // execute never completes a NONE->NONE move, so such words are skipped
  assign skip     = dec_src_unit == UNIT_NONE && dec_dst_unit == UNIT_NONE;

  assign instr_bus.valid = valid;
  assign instr_bus.addr  = pc + (state == FETCH_SRC_OP ? 32'd4 :
                                 state == FETCH_DST_OP ? (unit_has_operand(src_unit_o) ? 32'd8 : 32'd4) :
                                 32'd0);
  assign instr_bus.wstrb = 4'd0;
  assign instr_bus.instr = 1'b1;
  assign sel_o           = state == ISSUE || state == WAIT;
  assign pc_o            = pc;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= FETCH_INSTR;
    else       state <= state_n;
  end

  // done_i is only honoured in WAIT: execute may still hold the previous
  // instruction's done during ISSUE
  always_comb begin
    state_n = state;
    case (state)
      FETCH_INSTR:  if (hs) state_n = dec_src_has ? FETCH_SRC_OP :
                                      dec_dst_has ? FETCH_DST_OP :
                                      skip        ? FETCH_INSTR  : ISSUE;
      FETCH_SRC_OP: if (hs) state_n = unit_has_operand(dst_unit_o) ? FETCH_DST_OP : ISSUE;
      FETCH_DST_OP: if (hs) state_n = ISSUE;
      ISSUE:        state_n = WAIT;
      WAIT:         if (done_i) state_n = FETCH_INSTR;
      default:      state_n = FETCH_INSTR;
    endcase
  end

  // valid drops for one cycle after every handshake, giving the idle gap
  // between back-to-back requests
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid           <= 1'b0;
      pc              <= RESET_PC;
      len             <= 2'd0;
      src_unit_o      <= UNIT_NONE;
      src_immediate_o <= '0;
      src_operand_o   <= '0;
      dst_unit_o      <= UNIT_NONE;
      dst_immediate_o <= '0;
      dst_operand_o   <= '0;
    end else begin
      valid <= fetching && !hs;
      if (state == FETCH_INSTR && hs) begin
        src_unit_o      <= dec_src_unit;
        src_immediate_o <= dec_src_imm;
        src_operand_o   <= '0;
        dst_unit_o      <= dec_dst_unit;
        dst_immediate_o <= dec_dst_imm;
        dst_operand_o   <= '0;
        len             <= dec_len;
        if (skip) pc <= pc + 32'd4;
      end
      if (state == FETCH_SRC_OP && hs) src_operand_o <= instr_bus.read_data;
      if (state == FETCH_DST_OP && hs) dst_operand_o <= instr_bus.read_data;
      if (state == WAIT && done_i) pc <= pc + {28'd0, len, 2'b00};
    end
  end
endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: table-driven scoreboard bench for fetch_decode with a latency-configurable memory
module tb_fetch_decode;
  import fetch_decode_pkg::*;

  typedef struct {
    logic [31:0] pc, word, sop, dop;
    logic        has_s, has_d, skip;
    logic [3:0]  su, du;
    logic [11:0] si, di;
  } rec_t;

  logic clk = 1'b0;
  logic rst, done;
  logic sel_o;
  logic [31:0] pc_o, src_op, dst_op;
  Unit src_unit, dst_unit;
  logic [11:0] src_imm, dst_imm;

  bus_if bus();

  fetch_decode #(.RESET_PC(32'h0)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .instr_bus       (bus.master),
    .done_i          (done),
    .sel_o           (sel_o),
    .pc_o            (pc_o),
    .src_unit_o      (src_unit),
    .src_immediate_o (src_imm),
    .src_operand_o   (src_op),
    .dst_unit_o      (dst_unit),
    .dst_immediate_o (dst_imm),
    .dst_operand_o   (dst_op)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;
  int lat = 0, vcnt = 0;
  bit spur = 1'b0, late_ready = 1'b0;
  bit prev_hs = 1'b0, prev_valid = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] mem [64];
  logic [31:0] addr_q [$];
  rec_t exp_q [$];
  rec_t tbl [8];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      bus.ready = late_ready;
      bus.read_data = 32'hBAD0_0001;
      vcnt = 0;
      prev_hs = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (prev_hs) chk("valid_drop", 32'(bus.valid), 32'd0);
      else if (prev_valid && bus.valid) chk("addr_hold", bus.addr, prev_addr);
      if (bus.valid) begin
        vcnt++;
        bus.ready = vcnt > lat;
        bus.read_data = bus.ready ? mem[bus.addr[7:2]] : (32'hBAD0_0000 ^ 32'(vcnt));
        if (bus.ready) begin
          vcnt = 0;
          if (addr_q.size() == 0) chk("addr_extra", bus.addr, 32'hFFFF_FFFF);
          else chk("fetch_addr", bus.addr, addr_q.pop_front());
        end
      end else begin
        bus.ready = spur;
        bus.read_data = 32'hBAD0_BAD0;
      end
      prev_hs = bus.valid && bus.ready;
      prev_valid = bus.valid;
      prev_addr = bus.addr;
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, ".sel"}, 32'(sel_o), 32'd0);
    chk({tag, ".valid"}, 32'(bus.valid), 32'd0);
    chk({tag, ".pc"}, pc_o, 32'h0);
    chk({tag, ".src_unit"}, 32'(src_unit), 32'd0);
    chk({tag, ".src_imm"}, 32'(src_imm), 32'd0);
    chk({tag, ".src_op"}, src_op, 32'd0);
    chk({tag, ".dst_unit"}, 32'(dst_unit), 32'd0);
    chk({tag, ".dst_imm"}, 32'(dst_imm), 32'd0);
    chk({tag, ".dst_op"}, dst_op, 32'd0);
    chk({tag, ".wstrb"}, 32'(bus.wstrb), 32'd0);
    chk({tag, ".instr"}, 32'(bus.instr), 32'd1);
  endtask

  task automatic cmp_rec(input rec_t r, input string tag);
    chk({tag, ".sel"}, 32'(sel_o), 32'd1);
    chk({tag, ".pc"}, pc_o, r.pc);
    chk({tag, ".src_unit"}, 32'(src_unit), 32'(r.su));
    chk({tag, ".src_imm"}, 32'(src_imm), 32'(r.si));
    chk({tag, ".src_op"}, src_op, r.sop);
    chk({tag, ".dst_unit"}, 32'(dst_unit), 32'(r.du));
    chk({tag, ".dst_imm"}, 32'(dst_imm), 32'(r.di));
    chk({tag, ".dst_op"}, dst_op, r.dop);
  endtask

  task automatic wait_sel(output bit ok);
    for (int k = 0; k < 300 && !sel_o; k++) @(negedge clk);
    ok = sel_o;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rec_t r;
    bit ok;
    int idx;
    rst = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hBAD0_0000 | 32'(i);
    tbl[0] = '{32'h00, 32'h0031_05A2, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 4'h2, 4'h1, 12'h05A, 12'h003};
    tbl[1] = '{32'h04, 32'h1233_0071, 32'h0,         32'hCAFE_0001, 1'b0, 1'b1, 1'b0, 4'h1, 4'h3, 12'h007, 12'h123};
    tbl[2] = '{32'h0C, 32'hFFF1_800F, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 4'hF, 4'h1, 12'h800, 12'hFFF};
    tbl[3] = '{32'h10, 32'h0023_0014, 32'hDEAD_BEEF, 32'h0000_0100, 1'b1, 1'b1, 1'b0, 4'h4, 4'h3, 12'h001, 12'h002};
    tbl[4] = '{32'h1C, 32'h0202_0101, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 4'h1, 4'h2, 12'h010, 12'h020};
    tbl[5] = '{32'h20, 32'h0000_0000, 32'h0,         32'h0,         1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 12'h000, 12'h000};
    tbl[6] = '{32'h24, 32'h0011_3AB4, 32'h8000_0001, 32'h0,         1'b1, 1'b0, 1'b0, 4'h4, 4'h1, 12'h3AB, 12'h001};
    tbl[7] = '{32'h2C, 32'h0669_0550, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 4'h0, 4'h9, 12'h055, 12'h066};
    for (int i = 0; i < 8; i++) begin
      idx = int'(tbl[i].pc >> 2);
      mem[idx] = tbl[i].word;
      addr_q.push_back(tbl[i].pc);
      if (tbl[i].has_s) begin
        mem[idx + 1] = tbl[i].sop;
        addr_q.push_back(tbl[i].pc + 32'd4);
      end
      if (tbl[i].has_d) begin
        mem[idx + 1 + int'(tbl[i].has_s)] = tbl[i].dop;
        addr_q.push_back(tbl[i].pc + (tbl[i].has_s ? 32'd8 : 32'd4));
      end
      if (!tbl[i].skip) exp_q.push_back(tbl[i]);
    end
    mem[12] = 32'h0001_0004;
    mem[13] = 32'h5555_AAAA;
    addr_q.push_back(32'h30);

    @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    spur = 1'b1;

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].skip) continue;
      wait_sel(ok);
      chk($sformatf("e%0d.issue_seen", i), 32'(ok), 32'd1);
      r = exp_q.pop_front();
      cmp_rec(r, $sformatf("e%0d", i));
      if (i == 4) begin
        @(negedge clk);
        chk("stale_done", 32'(sel_o), 32'd1);
        done = 1'b0;
        repeat (2) @(negedge clk);
      end else repeat (1 + i % 3) @(negedge clk);
      cmp_rec(r, $sformatf("e%0d.hold", i));
      done = 1'b1;
      @(negedge clk);
      chk($sformatf("e%0d.sel_drop", i), 32'(sel_o), 32'd0);
      done = (i == 3);
      lat = (i == 7) ? 5 : (i >= 3) ? 3 : 0;
    end

    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = bus.valid && bus.addr == 32'h34;
    end
    chk("src_op_request", 32'(ok), 32'd1);
    rst = 1'b1;
    late_ready = 1'b1;
    addr_q.delete();
    addr_q.push_back(32'h00);
    addr_q.push_back(32'h04);
    @(negedge clk);
    chk_reset("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    late_ready = 1'b0;
    lat = 0;
    wait_sel(ok);
    chk("refetch.issue_seen", 32'(ok), 32'd1);
    cmp_rec(tbl[0], "refetch");
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    chk("refetch.sel_drop", 32'(sel_o), 32'd0);
    done = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
